// File: rtl/rep3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : rep3_serial_tx
// Description : Repetition-code serial transmitter. Takes a parallel word on
//               a valid/ready handshake and sends every data bit REP times in
//               a row on a 1-bit line. A 2-of-3 voter on the far end can then
//               recover each bit even if one copy is corrupted.
// Revision    : 1.0 - initial release
// ============================================================================
module rep3_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int REP       = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              bit_first,
    output logic              done
);

    localparam int c_REP_CW = (REP > 1) ? $clog2(REP) : 1;
    localparam int c_BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_REP_CW-1:0] c_REP_LAST = c_REP_CW'(REP - 1);
    localparam logic [c_BIT_CW-1:0] c_BIT_LAST = c_BIT_CW'(DATA_W - 1);
    // With a single copy per bit, every code bit closes its data bit.
    localparam logic c_REP_ONE = (REP == 1);
    // A word made of exactly one code bit: done rises on the very first bit.
    localparam logic c_ONE_BIT_WORD = (REP == 1) && (DATA_W == 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_REP_CW-1:0] r_rep_cnt;
    logic [c_BIT_CW-1:0] r_bit_cnt;
    logic                r_out;
    logic                r_out_valid;
    logic                r_bit_first;
    logic                r_done;

    logic                w_rep_end;
    logic                w_last;
    logic                w_accept;
    logic [c_REP_CW-1:0] w_rep_inc;
    logic [c_BIT_CW-1:0] w_bit_inc;
    logic [DATA_W-1:0]   w_shift_adv;
    logic                w_head_in;
    logic                w_head_adv;

    // Shift direction and the bit presented at the head of the word.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_adv = r_shift << 1;
            assign w_head_in   = in_data[DATA_W-1];
            assign w_head_adv  = w_shift_adv[DATA_W-1];
        end else begin : g_lsb_first
            assign w_shift_adv = r_shift >> 1;
            assign w_head_in   = in_data[0];
            assign w_head_adv  = w_shift_adv[0];
        end
    endgenerate

    // Counters describe the code bit currently on the line.
    assign w_rep_end = (r_rep_cnt == c_REP_LAST);
    assign w_last    = (r_state == S_SEND) && w_rep_end && (r_bit_cnt == c_BIT_LAST);
    assign w_rep_inc = r_rep_cnt + c_REP_CW'(1);
    assign w_bit_inc = r_bit_cnt + c_BIT_CW'(1);

    // Ready depends only on state and counters, never on in_valid.
    assign in_ready = (r_state == S_IDLE) || w_last;
    assign w_accept = in_valid && in_ready;

    // Single FSM: loads words, steps counters and registers the line outputs
    // for the next cycle so that they change only on the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_rep_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_bit_first <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_accept) begin
            // New word (from IDLE or from the last code bit of the previous one).
            r_state     <= S_SEND;
            r_shift     <= in_data;
            r_rep_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_out       <= w_head_in;
            r_out_valid <= 1'b1;
            r_bit_first <= 1'b1;
            r_done      <= c_ONE_BIT_WORD;
        end else if (r_state == S_SEND) begin
            if (w_last) begin
                // Word finished and nothing queued: drop back to an idle line.
                r_state     <= S_IDLE;
                r_shift     <= '0;
                r_rep_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_out       <= 1'b0;
                r_out_valid <= 1'b0;
                r_bit_first <= 1'b0;
                r_done      <= 1'b0;
            end else if (w_rep_end) begin
                // Last copy of this data bit: move on to the next data bit.
                r_rep_cnt   <= '0;
                r_bit_cnt   <= w_bit_inc;
                r_shift     <= w_shift_adv;
                r_out       <= w_head_adv;
                r_bit_first <= 1'b1;
                r_done      <= c_REP_ONE && (w_bit_inc == c_BIT_LAST);
            end else begin
                // Another copy of the same data bit.
                r_rep_cnt   <= w_rep_inc;
                r_bit_first <= 1'b0;
                r_done      <= (w_rep_inc == c_REP_LAST) && (r_bit_cnt == c_BIT_LAST);
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign bit_first = r_bit_first;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rep3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rep3_serial_tx
// Description : Scoreboard bench for rep3_serial_tx. One MSB-first and one
//               LSB-first instance; drivers push expected code bits, a
//               negedge monitor pops and compares them, and a 2-of-3 voter
//               recovers words from a corrupted copy of the MSB-first line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rep3_serial_tx;

    typedef logic [2:0] exp_t;   // {out, bit_first, done}

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] m_in_data, l_in_data;
    logic       m_in_valid, l_in_valid;
    logic       m_in_ready, l_in_ready;
    logic       m_out, l_out, m_out_valid, l_out_valid;
    logic       m_bit_first, l_bit_first, m_done, l_done;

    exp_t       q_m[$];
    exp_t       q_l[$];
    logic [7:0] vw_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int m_bits = 0;
    int d_prev = 0;
    int d_last = 0;
    int v_idx = 0;
    int v_flip = 0;
    int v_ones = 0;
    logic [7:0]  v_word = '0;
    logic [23:0] cap_m = '0;
    logic [23:0] cap_l = '0;
    logic [23:0] cap_bf_l = '0;

    always #5 clk = ~clk;

    rep3_serial_tx #(.DATA_W(8), .REP(3), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_data(m_in_data), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .out(m_out), .out_valid(m_out_valid),
        .bit_first(m_bit_first), .done(m_done)
    );

    rep3_serial_tx #(.DATA_W(8), .REP(3), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .out(l_out), .out_valid(l_out_valid),
        .bit_first(l_bit_first), .done(l_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Expected code stream of one word, three copies per bit.
    task automatic push_exp(input int ch, input logic [7:0] d);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = (ch == 0) ? d[7-i] : d[i];
            for (int r = 0; r < 3; r++) begin
                if (ch == 0) q_m.push_back({b, r == 0, (i == 7) && (r == 2)});
                else         q_l.push_back({b, r == 0, (i == 7) && (r == 2)});
            end
        end
    endtask

    task automatic mon(input int ch, input logic o, input logic ov, input logic bf,
                       input logic dn, input logic rdy);
        exp_t e;
        int   sz;
        sz = (ch == 0) ? q_m.size() : q_l.size();
        check("in_ready_rule", rdy, !ov || dn);
        if (ov) begin
            check("bit_expected", sz != 0, 1);
            if (sz != 0) begin
                e = (ch == 0) ? q_m.pop_front() : q_l.pop_front();
                check(ch == 0 ? "code_bit_msb" : "code_bit_lsb", {o, bf, dn}, e);
            end
        end else begin
            check("idle_outputs", {o, bf, dn}, 0);
            if (sz != 0) check("bit_on_time", ov, 1);
        end
    endtask

    // Monitor plus loopback voter with one flipped copy per triplet.
    always @(negedge clk) begin
        cyc++;
        mon(0, m_out, m_out_valid, m_bit_first, m_done, m_in_ready);
        mon(1, l_out, l_out_valid, l_bit_first, l_done, l_in_ready);
        if (m_out_valid) begin
            m_bits++;
            cap_m = {cap_m[22:0], m_out};
            if (m_bit_first) begin
                v_idx  = 0;
                v_ones = 0;
                v_flip = int'($urandom_range(0, 2));
            end
            v_ones += int'(m_out ^ (v_idx == v_flip));
            v_idx++;
            if (v_idx == 3) v_word = {v_word[6:0], v_ones >= 2};
            if (m_done) begin
                d_prev = d_last;
                d_last = cyc;
                check("voter_pending", vw_q.size() != 0, 1);
                if (vw_q.size() != 0) check("voter_word", v_word, vw_q.pop_front());
            end
        end
        if (l_out_valid) begin
            cap_l    = {cap_l[22:0], l_out};
            cap_bf_l = {cap_bf_l[22:0], l_bit_first};
        end
    end

    // Offer a word and hold in_valid until it is taken; in_valid stays high.
    task automatic send(input int ch, input logic [7:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        @(negedge clk);
        if (ch == 0) begin m_in_valid = 1'b1; m_in_data = d; end
        else         begin l_in_valid = 1'b1; l_in_data = d; end
        while (!acc && tries < 100) begin
            #1;
            if (ch == 0) begin
                acc = m_in_ready;
                if (acc && m_out_valid) check("accept_only_at_last", m_done, 1);
            end else begin
                acc = l_in_ready;
            end
            @(posedge clk);
            if (acc) begin
                push_exp(ch, d);
                if (ch == 0) vw_q.push_back(d);
            end else begin
                tries++;
                @(negedge clk);
            end
        end
        if (!acc) check("accept_timeout", acc, 1);
    endtask

    task automatic idle(input int ch);
        @(negedge clk);
        if (ch == 0) m_in_valid = 1'b0;
        else         l_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_m.size() + q_l.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", q_m.size() + q_l.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        reset_n    = 1'b0;
        m_in_valid = 1'b0;
        l_in_valid = 1'b0;
        m_in_data  = '0;
        l_in_data  = '0;
        #1;
        check("rst_out", {m_out, m_out_valid, m_bit_first, m_done}, 0);
        check("rst_ready", m_in_ready, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Word A5, MSB first.
        send(0, 8'hA5);
        idle(0);
        drain();
        check("a5_pattern", cap_m, 24'b111000111000000111000111);

        // Word 01, LSB first.
        send(1, 8'h01);
        idle(1);
        drain();
        check("lsb01_pattern", cap_l, 24'b111000000000000000000000);
        check("lsb01_bit_first", cap_bf_l, 24'b100100100100100100100100);

        // Back-to-back FF then 00.
        send(0, 8'hFF);
        send(0, 8'h00);
        idle(0);
        drain();
        check("b2b_done_spacing", d_last - d_prev, 24);

        // Mid-word in_valid pulse and in_data change are ignored.
        send(0, 8'h3C);
        idle(0);
        repeat (5) @(negedge clk);
        m_in_valid = 1'b1;
        m_in_data  = 8'hE7;
        @(negedge clk);
        m_in_valid = 1'b0;
        m_in_data  = 8'h18;
        repeat (3) @(negedge clk);
        send(0, 8'h5A);
        idle(0);
        drain();

        // Reset at code bit 10 of C3.
        base = m_bits;
        send(0, 8'hC3);
        idle(0);
        n = 0;
        while (m_bits < base + 10 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_bit10", m_bits - base, 10);
        #2;
        reset_n = 1'b0;
        q_m.delete();
        vw_q.delete();
        #1;
        check("async_rst_out", m_out, 0);
        check("async_rst_valid", m_out_valid, 0);
        check("async_rst_done", m_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", m_in_ready, 1);
        check("post_rst_valid", m_out_valid, 0);
        send(0, 8'h96);
        idle(0);
        drain();

        // Loopback voter over 1000 random words, back to back.
        for (int i = 0; i < 1000; i++) send(0, 8'($urandom));
        idle(0);
        drain();
        check("voter_all_checked", vw_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
